sudoku_board_mem: RTL

//   Responder end of the game-state RAM port driven by interfaceController.

---
 rtl/sudoku_board_mem.sv | 136 +++++++++++++
 1 files changed

// File: rtl/sudoku_board_mem.sv
// rtl/sudoku_board_mem.sv - 4x24-bit sudoku board RAM with puzzle ROM load, write-protect and solved check
// Word layout: [23:20] write-protect, [19:16] blank flags, [15:0] digits (col0 in [3:0]).
module sudoku_board_mem #(
    parameter int WORD_W = 24,
    parameter int PUZ_W  = 2,
    parameter int ROM_AW = PUZ_W + 2
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [1:0]        RamAddr,
    input  logic              RamWriteBit,
    input  logic [WORD_W-1:0] RamWriteBuf,
    output logic [WORD_W-1:0] RamDat,
    input  logic [PUZ_W-1:0]  puzzleSel,
    input  logic              loadReq,
    output logic [ROM_AW-1:0] RomAddr,
    input  logic [WORD_W-1:0] RomDat,
    output logic              ready,
    output logic              solved
);

    typedef enum logic {
        S_LOAD = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [2:0]        r_cnt;
    logic [PUZ_W-1:0]  r_sel;
    logic              r_ready;
    logic              r_solved;
    logic [WORD_W-1:0] r_mem [4];
    logic [WORD_W-1:0] w_old_word;
    logic [WORD_W-1:0] w_wr_word;
    logic [1:0]        w_load_row;
    logic              w_solved;
    logic [3:0]        w_row_seen;
    logic [3:0]        w_col_seen;
    logic [3:0]        w_box_seen;
    logic [3:0]        w_unused_buf;

    assign w_unused_buf = RamWriteBuf[23:20];
    assign RamDat       = r_mem[RamAddr];
    assign RomAddr      = {r_sel, r_cnt[1:0]};
    assign ready        = r_ready;
    assign solved       = r_solved;
    assign w_old_word   = r_mem[RamAddr];
    // ROM data lags the address by one cycle, so load cycle k fills row k-1
    assign w_load_row   = r_cnt[1:0] - 2'd1;

    function automatic logic [3:0] f_onehot(input logic [3:0] d);
        case (d)
            4'd1:    f_onehot = 4'b0001;
            4'd2:    f_onehot = 4'b0010;
            4'd3:    f_onehot = 4'b0100;
            4'd4:    f_onehot = 4'b1000;
            default: f_onehot = 4'b0000;
        endcase
    endfunction

    always_comb begin
        w_wr_word        = w_old_word;
        w_wr_word[23:20] = w_old_word[23:20];
        for (int i = 0; i < 4; i++) begin
            if (!w_old_word[20+i]) begin
                w_wr_word[16+i]    = RamWriteBuf[16+i];
                w_wr_word[4*i +: 4] = RamWriteBuf[4*i +: 4];
            end
        end
    end

    // Out-of-range digits contribute nothing, so a full 4'hF mask also proves the 1..4 range
    always_comb begin
        w_solved   = 1'b1;
        w_row_seen = 4'h0;
        w_col_seen = 4'h0;
        w_box_seen = 4'h0;
        for (int g = 0; g < 4; g++) begin
            w_row_seen = 4'h0;
            w_col_seen = 4'h0;
            w_box_seen = 4'h0;
            if (r_mem[g][19:16] != 4'h0) w_solved = 1'b0;
            for (int k = 0; k < 4; k++) begin
                w_row_seen = w_row_seen | f_onehot(r_mem[g][4*k +: 4]);
                w_col_seen = w_col_seen | f_onehot(r_mem[k][4*g +: 4]);
                w_box_seen = w_box_seen |
                    f_onehot(r_mem[(g/2)*2 + k/2][4*((g%2)*2 + k%2) +: 4]);
            end
            if (w_row_seen != 4'hF || w_col_seen != 4'hF || w_box_seen != 4'hF)
                w_solved = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) r_state <= S_LOAD;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_LOAD:  if (r_cnt == 3'd4) w_state_nxt = S_RUN;
            S_RUN:   if (loadReq)       w_state_nxt = S_LOAD;
            default: w_state_nxt = S_LOAD;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_sel    <= puzzleSel;
            r_cnt    <= 3'd0;
            r_ready  <= 1'b0;
            r_solved <= 1'b0;
            for (int i = 0; i < 4; i++) r_mem[i] <= '0;
        end else if (r_state == S_LOAD) begin
            r_solved <= 1'b0;
            if (r_cnt != 3'd0) r_mem[w_load_row] <= RomDat;
            if (r_cnt == 3'd4) begin
                r_cnt   <= 3'd0;
                r_ready <= 1'b1;
            end else begin
                r_cnt <= r_cnt + 3'd1;
            end
        end else if (loadReq) begin
            r_sel    <= puzzleSel;
            r_cnt    <= 3'd0;
            r_ready  <= 1'b0;
            r_solved <= 1'b0;
        end else begin
            if (RamWriteBit) r_mem[RamAddr] <= w_wr_word;
            r_solved <= w_solved;
        end
    end

endmodule
